rr_mux_arbiter: RTL and testbench

Round-robin arbiter that shares one 32-bit 4:1 word multiplexer among four requesters feeding a single consumer (e.g. a shared writeback or memory port). It registers a one-hot grant, drives the mux selector from that grant, and runs a valid/ready handshake toward the consumer with per-requester accept pulses. Grants rotate fairly; an optional lock extends a grant into a bounded burst.

---
 rtl/rr_mux_arbiter.sv | 134 +++++++++++++
 tb/tb_rr_mux_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin grant of a 4:1 word mux to one consumer; `RR_MUX_ARBITER_LOCK_EN enables locked bursts.
// Latency: grant registered the cycle after req; one idle bubble follows every release.
// Backpressure: gnt/sel and the selected word hold while out_ready is low; accept strobes once per transfer.
module rr_mux_arbiter #(
  parameter int WIDTH     = 32,
  parameter int MAX_BEATS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [3:0]       lock,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [WIDTH-1:0] data3,
  input  logic             out_ready,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [3:0]       accept,
  output logic             busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state, state_nxt;
  logic [3:0] gnt_nxt;
  logic [1:0] sel_nxt;
  logic [1:0] ptr, ptr_nxt;
  logic [1:0] pick;
  logic       xfer;
  logic       last_beat;

  // First requester at or after ptr; descending scan lets the nearest one win.
  always_comb begin
    pick = ptr;
    for (int k = 3; k >= 0; k--) begin
      if (req[ptr + 2'(k)]) pick = ptr + 2'(k);
    end
  end

  always_comb begin
    case (sel)
      2'd0:    out_data = data0;
      2'd1:    out_data = data1;
      2'd2:    out_data = data2;
      default: out_data = data3;
    endcase
  end

  // A cycle with reset asserted never transfers, so an aborted word is not accepted.
  assign out_valid = rst_n & (|gnt) & req[sel];
  assign xfer      = out_valid & out_ready;
  assign accept    = gnt & {4{xfer}};
  assign busy      = (state == GRANT);

`ifdef RR_MUX_ARBITER_LOCK_EN
  localparam int BW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  logic [BW-1:0] beat_cnt, beat_nxt;

  assign last_beat = !lock[sel] || (int'(beat_cnt) + 1 == MAX_BEATS);
`else
  logic lock_unused;

  assign lock_unused = (^lock) ^ (MAX_BEATS < 1);
  assign last_beat   = 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    sel_nxt   = sel;
    ptr_nxt   = ptr;
`ifdef RR_MUX_ARBITER_LOCK_EN
    beat_nxt  = beat_cnt;
`endif
    case (state)
      IDLE: begin
        if (|req) begin
          gnt_nxt   = 4'b0001 << pick;
          sel_nxt   = pick;
          state_nxt = GRANT;
`ifdef RR_MUX_ARBITER_LOCK_EN
          beat_nxt  = '0;
`endif
        end
      end
      GRANT: begin
        if (xfer) begin
          if (last_beat) begin
            ptr_nxt   = sel + 2'd1;
            gnt_nxt   = 4'b0000;
            state_nxt = IDLE;
          end
`ifdef RR_MUX_ARBITER_LOCK_EN
          else begin
            beat_nxt = beat_cnt + BW'(1);
          end
`endif
        end else if (!req[sel]) begin
          // Withdrawn request: give up the grant without moving priority.
          gnt_nxt   = 4'b0000;
          state_nxt = IDLE;
        end
      end
      default: begin
        gnt_nxt   = 4'b0000;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= 4'b0000;
      sel      <= 2'b00;
      ptr      <= 2'b00;
`ifdef RR_MUX_ARBITER_LOCK_EN
      beat_cnt <= '0;
`endif
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      sel      <= sel_nxt;
      ptr      <= ptr_nxt;
`ifdef RR_MUX_ARBITER_LOCK_EN
      beat_cnt <= beat_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: per-requester behavioural model plus a transfer scoreboard drained by a monitor.
module tb_rr_mux_arbiter;

  localparam int W  = 32;
  localparam int MB = 4;
`ifdef RR_MUX_ARBITER_LOCK_EN
  localparam bit LOCK_ON = 1'b1;
`else
  localparam bit LOCK_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    req;
  logic [3:0]    lock;
  logic [W-1:0]  dat [4];
  logic          out_ready;
  logic [3:0]    gnt;
  logic [1:0]    sel;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic [3:0]    accept;
  logic          busy;

  rr_mux_arbiter #(.WIDTH(W), .MAX_BEATS(MB)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .lock(lock),
    .data0(dat[0]), .data1(dat[1]), .data2(dat[2]), .data3(dat[3]),
    .out_ready(out_ready), .gnt(gnt), .sel(sel), .out_valid(out_valid),
    .out_data(out_data), .accept(accept), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]   id;
    logic [W-1:0] data;
  } xfer_t;

  xfer_t sb_q[$];
  int    acc_log[$];
  int    n_chk  = 0;
  int    n_fail = 0;

  // Model state: who owns the port (-1 = nobody), who has priority, beats used, last selector.
  int owner, prio, beats, last_sel;
  int seq [4] = '{0, 0, 0, 0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pack_log(input int n);
    logic [31:0] r = '0;
    for (int i = 0; i < n; i++)
      r = (r << 4) | ((i < acc_log.size()) ? 32'(acc_log[i]) : 32'hF);
    return r;
  endfunction

  // Expected outputs for this cycle, then advance the model across the coming edge.
  task automatic model_cycle();
    logic [3:0] e_gnt;
    bit         e_valid, e_xfer, done;
    e_gnt   = (owner < 0) ? 4'b0000 : (4'b0001 << owner);
    e_valid = rst_n && owner >= 0 && req[owner];
    e_xfer  = e_valid && out_ready;
    chk("gnt", 32'(gnt), 32'(e_gnt));
    chk("sel", 32'(sel), 32'(last_sel));
    chk("out_valid", 32'(out_valid), 32'(e_valid));
    chk("busy", 32'(busy), 32'(owner >= 0));
    chk("accept", 32'(accept), e_xfer ? 32'(e_gnt) : 32'h0);
    if (e_valid) chk("out_data", out_data, dat[owner]);
    if (e_xfer) begin
      sb_q.push_back('{id: 2'(owner), data: dat[owner]});
      seq[owner]++;
    end
    if (!rst_n) begin
      owner = -1; prio = 0; beats = 0; last_sel = 0;
    end else if (owner < 0) begin
      for (int k = 0; k < 4; k++) begin
        if (owner < 0 && req[(prio + k) % 4]) begin
          owner = (prio + k) % 4; last_sel = owner; beats = 0;
        end
      end
    end else if (e_xfer) begin
      beats++;
      done = !LOCK_ON || !lock[owner] || beats == MB;
      if (done) begin
        prio = (owner + 1) % 4; owner = -1;
      end
    end else if (!req[owner]) begin
      owner = -1;
    end
  endtask

  task automatic run_cycle(input logic rn, input logic [3:0] rq, input logic [3:0] lk, input logic rdy);
    rst_n = rn; req = rq; lock = lk; out_ready = rdy;
    for (int i = 0; i < 4; i++) dat[i] = 32'hA0 + 32'(i) + (32'(seq[i]) << 8);
    #1;
    model_cycle();
    @(posedge clk); #1;
  endtask

  // Monitor: every DUT transfer must match the oldest predicted one.
  initial begin
    xfer_t e;
    int    id;
    forever begin
      @(negedge clk);
      if (accept !== 4'b0000) begin
        id = 0;
        for (int i = 0; i < 4; i++) if (accept[i]) id = i;
        chk("sb_onehot", 32'($onehot(accept)), 32'h1);
        acc_log.push_back(id);
        if (sb_q.size() == 0) begin
          chk("sb_unexpected", 32'(accept), 32'h0);
        end else begin
          e = sb_q.pop_front();
          chk("sb_id", 32'(id), 32'(e.id));
          chk("sb_data", out_data, e.data);
        end
      end
    end
  end

  initial begin
    logic [3:0] rq;
    logic [3:0] lk;
    rst_n = 1'b0; req = 4'hF; lock = 4'h0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) dat[i] = 32'hA0 + 32'(i);
    @(posedge clk); #1;
    owner = -1; prio = 0; beats = 0; last_sel = 0;

    // Reset held with all requests up, then release.
    repeat (3) run_cycle(1'b0, 4'hF, 4'h0, 1'b1);
    run_cycle(1'b1, 4'hF, 4'h0, 1'b1);

    // Unlocked rotation with all requesters active.
    acc_log.delete();
    repeat (10) run_cycle(1'b1, 4'hF, 4'h0, 1'b1);
    chk("rotation_order", pack_log(5), 32'h01230);

    // Stall on requester 2 for five cycles, then one transfer.
    repeat (2) run_cycle(1'b1, 4'h0, 4'h0, 1'b0);
    acc_log.delete();
    repeat (6) run_cycle(1'b1, 4'b0100, 4'h0, 1'b0);
    run_cycle(1'b1, 4'b0100, 4'h0, 1'b1);
    repeat (2) run_cycle(1'b1, 4'h0, 4'h0, 1'b1);
    chk("stall_single_accept", pack_log(2), 32'h2F);

    // Withdraw by requester 1 keeps its priority.
    run_cycle(1'b0, 4'h0, 4'h0, 1'b0);
    run_cycle(1'b1, 4'b0010, 4'h0, 1'b0);
    run_cycle(1'b1, 4'b0000, 4'h0, 1'b0);
    run_cycle(1'b1, 4'b1010, 4'h0, 1'b0);
    chk("withdraw_regrant", 32'(gnt), 32'h2);
    run_cycle(1'b1, 4'b0000, 4'h0, 1'b0);

    // Locked burst from requester 0 against requester 1.
    run_cycle(1'b0, 4'h0, 4'h0, 1'b1);
    acc_log.delete();
    repeat (12) run_cycle(1'b1, 4'b0011, 4'b0001, 1'b1);
    chk("burst_order", pack_log(5), LOCK_ON ? 32'h00001 : 32'h01010);

    // Reset during the third beat of a burst.
    run_cycle(1'b0, 4'h0, 4'h0, 1'b1);
    repeat (3) run_cycle(1'b1, 4'b0011, 4'b0001, 1'b1);
    run_cycle(1'b0, 4'b0011, 4'b0001, 1'b1);
    run_cycle(1'b1, 4'b0011, 4'b0001, 1'b1);
    chk("reset_regrant", 32'(gnt), 32'h1);

    // Random traffic with sticky requests, stalls and occasional resets.
    rq = 4'h0; lk = 4'h0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) rq = 4'($urandom);
      if ($urandom_range(0, 3) == 0) lk = 4'($urandom);
      run_cycle(($urandom_range(0, 63) != 0), rq, lk, ($urandom_range(0, 3) != 0));
    end
    run_cycle(1'b1, 4'h0, 4'h0, 1'b0);
    @(negedge clk); #1;
    chk("sb_drain", 32'(sb_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
